uart_rx_ext: RTL and testbench
==============================

UART_RX_EXT -- requirements
Module: uart_rx_ext

Interface
REQ-001 Parameter DBIT, default 8, number of data bits, legal range 5..9.
REQ-002 Parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-003 Parameter SB, default 1, number of stop bits, legal values 1 or 2.
REQ-004 Parameter OVS, default 16, s_tick ticks per bit, legal values 8 or 16.
REQ-005 clk  input  1  system clock, all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 rx  input  1  serial line, idle high, asynchronous to clk.
REQ-008 s_tick  input  1  one-clk oversampling strobe, OVS per bit period.
REQ-009 rx_done_tick  output  1  one-clk pulse, frame complete.
REQ-010 dout  output  DBIT  received data, LSB is first bit on the line.
REQ-011 parity_err  output  1  parity mismatch on the last frame; always 0 when PARITY=0.
REQ-012 frame_err  output  1  any stop bit sampled low on the last frame.
REQ-013 break_det  output  1  last frame was all-zero including parity and stop bits.

Function
REQ-014 rx passes through a 2-flop synchronizer; all FSM decisions use the synchronized value rxs.
REQ-015 States: IDLE, START, DATA, PARITY, STOP, RECOVER; counters: s (tick count, log2(OVS) bits), n (bit index), b (shift register).
REQ-016 IDLE: on rxs==0, go to START with s=0; s_tick is not required.
REQ-017 START: on each s_tick, s increments; on the s_tick with s==OVS/2-1, if rxs==1, return to IDLE with no output (glitch rejection); otherwise go to DATA with s=0, n=0.
REQ-018 DATA/PARITY/STOP bit sampling: rxs is captured on the s_ticks with s==OVS-3, OVS-2, OVS-1; the bit value is the 2-of-3 majority, resolved on the s_tick with s==OVS-1, after which s wraps to 0.
REQ-019 DATA: each resolved bit shifts into b from the MSB side (b={bit,b[DBIT-1:1]}); after bit n==DBIT-1, go to PARITY if PARITY!=0, else go to STOP with n=0.
REQ-020 PARITY: the resolved bit is stored; parity fails when XOR(data, parity bit) is 1 for even, or 0 for odd; then go to STOP with n=0.
REQ-021 STOP: SB bit periods; a low resolved stop bit sets an internal frame flag; after the last stop bit the frame completes.
REQ-022 Frame completion, one clk after the completing s_tick edge:
  - rx_done_tick=1 for exactly one clk;
  - dout, parity_err, frame_err and break_det update together;
  - all four are registered and hold until the next completion.
REQ-023 break_det=1 iff all data bits, the parity bit (if present) and every stop bit resolved 0; break_det=1 implies frame_err=1.
REQ-024 After completion: if frame_err, go to RECOVER; otherwise go to IDLE.
REQ-025 RECOVER: remain until rxs==1, then go to IDLE, so a held-low line does not start new frames.
REQ-026 s_tick is ignored in IDLE and RECOVER; with no s_tick, all counters hold.
REQ-027 Back-to-back frames: a start edge in the clk after completion is accepted without loss.
REQ-028 rx_done_tick is never asserted for a rejected glitch or while in RECOVER.

Reset
REQ-029 Reset forces state IDLE; s, n, b and synchronizer flops go to 0/idle-high-safe values; synchronizer outputs reset to 1.
REQ-030 Reset values: rx_done_tick=0, dout=0, parity_err=0, frame_err=0, break_det=0.
REQ-031 Reset asserted mid-frame aborts the frame with no rx_done_tick; after release, reception restarts only on a new falling edge.

Verification
REQ-032 Defaults, s_tick every 4 clk, send 0xA5, 1 stop -> one rx_done_tick, dout=0xA5, all error flags 0.
REQ-033 DBIT=7, PARITY=1, SB=2 -> send 0x55 with correct parity=0 gives parity_err=0; send the same frame with parity=1 gives parity_err=1, dout=0x55.
REQ-034 rx low for 3 ticks, then high -> return to IDLE, no rx_done_tick; the following valid 0x3C frame is received correctly.
REQ-035 Defaults, hold rx low for 20 bit periods, then high -> exactly one rx_done_tick with dout=0x00, frame_err=1, break_det=1; no second frame until rx goes high.
REQ-036 Data bit 3 disturbed by a one-tick low glitch at s==OVS-2 within a 1 bit -> majority vote yields 1; 0xFF is received intact.
REQ-037 Reset pulse mid-byte, then send 0x81 -> outputs 0 during reset, single rx_done_tick afterwards with dout=0x81.

Source files
------------

// File: rtl/uart_rx_ext.sv
// uart_rx_ext: oversampled UART receiver with a 2-flop input synchronizer,
// 2-of-3 majority bit sampling, optional parity, 1 or 2 stop bits, and
// framing/break detection with a recover state for a held-low line.
module uart_rx_ext #(
  parameter int DBIT   = 8,   // data bits, 5..9
  parameter int PARITY = 0,   // 0 none, 1 even, 2 odd
  parameter int SB     = 1,   // stop bits, 1 or 2
  parameter int OVS    = 16   // s_tick strobes per bit, 8 or 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic            rx_done_tick,
  output logic [DBIT-1:0] dout,
  output logic            parity_err,
  output logic            frame_err,
  output logic            break_det
);

  localparam int SW = $clog2(OVS);
  localparam int NW = 4;

  localparam logic [SW-1:0] S_HALF = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] S_V0   = SW'(OVS - 3);
  localparam logic [SW-1:0] S_V1   = SW'(OVS - 2);
  localparam logic [SW-1:0] S_LAST = SW'(OVS - 1);
  localparam logic [NW-1:0] N_DLAST = NW'(DBIT - 1);
  localparam logic [NW-1:0] N_SLAST = NW'(SB - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_RECOVER
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [1:0]      vote_q, vote_d;       // first two of the three bit samples
  logic            par_bit_q, par_bit_d;
  logic            stop_low_q, stop_low_d; // some stop bit resolved low
  logic            any_one_q, any_one_d;   // some resolved bit of this frame was 1

  logic            done_d;
  logic [DBIT-1:0] dout_d;
  logic            perr_d, ferr_d, brk_d;

  logic            rx_meta, rxs;
  logic            bit_val, bit_end, par_xor;

  // Two-flop synchronizer for the asynchronous serial line.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values; both flops reset to 1 so an idle-high line
  // never looks like a start edge when reset releases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // Majority of the samples taken at s == OVS-3, OVS-2 and the current one.
  assign bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxs) | (vote_q[1] & rxs);
  assign bit_end = s_tick && (s_q == S_LAST);
  assign par_xor = (^b_q) ^ par_bit_q;

  // Next-state, counters and completion outputs.
  // NOTE: every signal driven here gets its hold value first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    n_d        = n_q;
    b_d        = b_q;
    vote_d     = vote_q;
    par_bit_d  = par_bit_q;
    stop_low_d = stop_low_q;
    any_one_d  = any_one_q;
    done_d     = 1'b0;
    dout_d     = dout;
    perr_d     = parity_err;
    ferr_d     = frame_err;
    brk_d      = break_det;

    // Shared tick counter and vote capture for every sampled bit period.
    if ((state_q == ST_DATA || state_q == ST_PARITY || state_q == ST_STOP) && s_tick) begin
      if (s_q == S_V0) vote_d[0] = rxs;
      if (s_q == S_V1) vote_d[1] = rxs;
      s_d = bit_end ? '0 : s_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (!rxs) begin
          state_d = ST_START;
          s_d     = '0;
        end
      end

      ST_START: begin
        if (s_tick) begin
          if (s_q == S_HALF) begin
            if (rxs) begin
              state_d = ST_IDLE;          // start bit did not last: glitch
            end else begin
              state_d    = ST_DATA;
              s_d        = '0;
              n_d        = '0;
              any_one_d  = 1'b0;
              stop_low_d = 1'b0;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          b_d       = {bit_val, b_q[DBIT-1:1]};
          any_one_d = any_one_q | bit_val;
          if (n_q == N_DLAST) begin
            n_d     = '0;
            state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            n_d = n_q + 1'b1;
          end
        end
      end

      ST_PARITY: begin
        if (bit_end) begin
          par_bit_d = bit_val;
          any_one_d = any_one_q | bit_val;
          n_d       = '0;
          state_d   = ST_STOP;
        end
      end

      ST_STOP: begin
        if (bit_end) begin
          stop_low_d = stop_low_q | ~bit_val;
          any_one_d  = any_one_q | bit_val;
          if (n_q == N_SLAST) begin
            done_d = 1'b1;
            dout_d = b_q;
            if (PARITY == 1)      perr_d = par_xor;
            else if (PARITY == 2) perr_d = ~par_xor;
            else                  perr_d = 1'b0;
            ferr_d  = stop_low_q | ~bit_val;
            brk_d   = ~(any_one_q | bit_val);
            state_d = ferr_d ? ST_RECOVER : ST_IDLE;
          end else begin
            n_d = n_q + 1'b1;
          end
        end
      end

      ST_RECOVER: begin
        if (rxs) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and registered frame outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      s_q          <= '0;
      n_q          <= '0;
      b_q          <= '0;
      vote_q       <= 2'b11;
      par_bit_q    <= 1'b0;
      stop_low_q   <= 1'b0;
      any_one_q    <= 1'b0;
      rx_done_tick <= 1'b0;
      dout         <= '0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      break_det    <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      n_q          <= n_d;
      b_q          <= b_d;
      vote_q       <= vote_d;
      par_bit_q    <= par_bit_d;
      stop_low_q   <= stop_low_d;
      any_one_q    <= any_one_d;
      rx_done_tick <= done_d;
      dout         <= dout_d;
      parity_err   <= perr_d;
      frame_err    <= ferr_d;
      break_det    <= brk_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_ext.sv
// tb_uart_rx_ext: scoreboard bench for uart_rx_ext. Instance a uses the
// defaults (8N1, OVS 16); instance b is 7 data bits, even parity, 2 stops.
`timescale 1ns/1ps
module tb_uart_rx_ext;

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick;
  logic       rx_a, rx_b;
  logic       done_a, done_b;
  logic [7:0] dout_a;
  logic [6:0] dout_b;
  logic       perr_a, ferr_a, brk_a;
  logic       perr_b, ferr_b, brk_b;

  exp_t sb_a[$];
  exp_t sb_b[$];
  exp_t ea, eb;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   done_cnt_a = 0;
  int   done_cnt_b = 0;
  logic prev_a = 1'b0;
  logic prev_b = 1'b0;

  uart_rx_ext dut_a (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx_a),
    .s_tick       (s_tick),
    .rx_done_tick (done_a),
    .dout         (dout_a),
    .parity_err   (perr_a),
    .frame_err    (ferr_a),
    .break_det    (brk_a)
  );

  uart_rx_ext #(.DBIT(7), .PARITY(1), .SB(2), .OVS(16)) dut_b (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx_b),
    .s_tick       (s_tick),
    .rx_done_tick (done_b),
    .dout         (dout_b),
    .parity_err   (perr_b),
    .frame_err    (ferr_b),
    .break_det    (brk_b)
  );

  always #5 clk = ~clk;

  // s_tick: one clk high every 4 clks, changed on the falling edge.
  initial begin
    s_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wait for k s_tick edges, then return on the following falling edge.
  task automatic wait_ticks(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      while (s_tick !== 1'b1) @(posedge clk);
    end
    @(negedge clk);
  endtask

  task automatic set_rx(input int which, input logic v);
    if (which == 0) rx_a = v;
    else            rx_b = v;
  endtask

  // Drive one frame and push its expected result. glitch_bit >= 0 puts a
  // one-tick low pulse on that data bit around its middle vote sample.
  task automatic send_frame(input int which, input logic [8:0] data, input logic par_bit,
                            input logic [1:0] stops, input int glitch_bit);
    int         nb = (which == 0) ? 8 : 7;
    int         ns = (which == 0) ? 1 : 2;
    logic [8:0] mask;
    logic [8:0] d;
    logic       all_stops_low;
    exp_t       e;
    mask          = (9'h001 << nb) - 9'h001;
    d             = data & mask;
    all_stops_low = (ns == 1) ? !stops[0] : (!stops[0] && !stops[1]);
    e.data = d;
    e.perr = (which == 1) ? ((^d) ^ par_bit) : 1'b0;
    e.ferr = (ns == 1) ? !stops[0] : (!stops[0] || !stops[1]);
    e.brk  = (d == 9'h000) && (which == 0 || par_bit == 1'b0) && all_stops_low;
    if (which == 0) sb_a.push_back(e);
    else            sb_b.push_back(e);

    wait_ticks(1);
    set_rx(which, 1'b0);
    wait_ticks(16);
    for (int i = 0; i < nb; i++) begin
      set_rx(which, data[i]);
      if (i == glitch_bit) begin
        wait_ticks(6);
        set_rx(which, 1'b0);
        wait_ticks(1);
        set_rx(which, data[i]);
        wait_ticks(9);
      end else begin
        wait_ticks(16);
      end
    end
    if (which == 1) begin
      set_rx(which, par_bit);
      wait_ticks(16);
    end
    for (int i = 0; i < ns; i++) begin
      set_rx(which, stops[i]);
      wait_ticks(16);
    end
    set_rx(which, 1'b1);
  endtask

  // Scoreboard monitor for instance a.
  always @(negedge clk) begin
    if (prev_a) check("a_done_one_clk", 32'(done_a), 32'd0);
    if (done_a) begin
      done_cnt_a++;
      if (sb_a.size() == 0) begin
        check("a_unexpected_done", 32'(done_a), 32'd0);
      end else begin
        ea = sb_a.pop_front();
        check("a_dout",       32'(dout_a), 32'(ea.data));
        check("a_parity_err", 32'(perr_a), 32'(ea.perr));
        check("a_frame_err",  32'(ferr_a), 32'(ea.ferr));
        check("a_break_det",  32'(brk_a),  32'(ea.brk));
      end
    end
    prev_a <= done_a;
  end

  // Scoreboard monitor for instance b.
  always @(negedge clk) begin
    if (prev_b) check("b_done_one_clk", 32'(done_b), 32'd0);
    if (done_b) begin
      done_cnt_b++;
      if (sb_b.size() == 0) begin
        check("b_unexpected_done", 32'(done_b), 32'd0);
      end else begin
        eb = sb_b.pop_front();
        check("b_dout",       32'(dout_b), 32'(eb.data));
        check("b_parity_err", 32'(perr_b), 32'(eb.perr));
        check("b_frame_err",  32'(ferr_b), 32'(eb.ferr));
        check("b_break_det",  32'(brk_b),  32'(eb.brk));
      end
    end
    prev_b <= done_b;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    reset = 1'b1;
    rx_a  = 1'b1;
    rx_b  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_a_done", 32'(done_a), 32'd0);
    check("rst_a_dout", 32'(dout_a), 32'd0);
    check("rst_a_perr", 32'(perr_a), 32'd0);
    check("rst_a_ferr", 32'(ferr_a), 32'd0);
    check("rst_a_brk",  32'(brk_a),  32'd0);
    check("rst_b_done", 32'(done_b), 32'd0);
    check("rst_b_dout", 32'(dout_b), 32'd0);
    reset = 1'b0;
    wait_ticks(4);

    // Basic 8N1 frame.
    send_frame(0, 9'h0A5, 1'b0, 2'b11, -1);

    // 7E2: good parity, bad parity, all-ones data, low second stop bit.
    send_frame(1, 9'h055, 1'b0, 2'b11, -1);
    send_frame(1, 9'h07F, 1'b1, 2'b11, -1);
    send_frame(1, 9'h055, 1'b0, 2'b01, -1);
    wait_ticks(4);
    send_frame(1, 9'h055, 1'b1, 2'b11, -1);

    // Short low pulse on the line is rejected, next frame is clean.
    wait_ticks(1);
    rx_a = 1'b0;
    wait_ticks(3);
    rx_a = 1'b1;
    wait_ticks(16);
    send_frame(0, 9'h03C, 1'b0, 2'b11, -1);

    // One-tick low glitch inside data bit 3 is outvoted.
    send_frame(0, 9'h0FF, 1'b0, 2'b11, 3);

    // Break: line held low for 20 bit periods gives exactly one frame.
    sb_a.push_back('{data: 9'h000, perr: 1'b0, ferr: 1'b1, brk: 1'b1});
    c0 = done_cnt_a;
    wait_ticks(1);
    rx_a = 1'b0;
    wait_ticks(320);
    check("break_done_count", 32'(done_cnt_a - c0), 32'd1);
    check("break_ferr_hold",  32'(ferr_a), 32'd1);
    check("break_brk_hold",   32'(brk_a),  32'd1);
    rx_a = 1'b1;
    wait_ticks(16);

    // Reset mid-byte aborts the frame and clears all outputs.
    wait_ticks(1);
    rx_a = 1'b0;
    wait_ticks(16);
    rx_a = 1'b1;
    wait_ticks(16);
    rx_a = 1'b0;
    wait_ticks(24);
    reset = 1'b1;
    rx_a  = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_a_done", 32'(done_a), 32'd0);
    check("mid_rst_a_dout", 32'(dout_a), 32'd0);
    check("mid_rst_a_ferr", 32'(ferr_a), 32'd0);
    check("mid_rst_a_brk",  32'(brk_a),  32'd0);
    check("mid_rst_b_dout", 32'(dout_b), 32'd0);
    check("mid_rst_b_perr", 32'(perr_b), 32'd0);
    reset = 1'b0;
    wait_ticks(16);
    send_frame(0, 9'h081, 1'b0, 2'b11, -1);

    wait_ticks(32);
    check("a_sb_drained",  32'(sb_a.size()), 32'd0);
    check("b_sb_drained",  32'(sb_b.size()), 32'd0);
    check("a_done_total",  32'(done_cnt_a), 32'd5);
    check("b_done_total",  32'(done_cnt_b), 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
